// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the keypad emulator.
// Scan vector order is {A,B,C,D}; row vector order is {E,F,G}.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'ha;
    localparam logic [3:0] KEY_B    = 4'hb;
    localparam logic [3:0] KEY_C    = 4'hc;
    localparam logic [3:0] KEY_NONE = 4'hf;

    // Codes 1..c map to a key; 0, d, e, f do not.
    function automatic logic key_is_valid(input logic [3:0] code);
        return (code >= KEY_1) && (code <= KEY_C);
    endfunction

    // Which scan line the key sits on, one-hot {A,B,C,D}.
    function automatic logic [3:0] key_to_scan(input logic [3:0] code);
        logic [3:0] scan;
        case (code)
            KEY_1, KEY_2, KEY_3: scan = 4'b1000;
            KEY_4, KEY_5, KEY_6: scan = 4'b0100;
            KEY_7, KEY_8, KEY_9: scan = 4'b0010;
            KEY_A, KEY_B, KEY_C: scan = 4'b0001;
            default:             scan = 4'b0000;
        endcase
        return scan;
    endfunction

    // Which row the key returns on, one-hot {E,F,G}.
    function automatic logic [2:0] key_to_row(input logic [3:0] code);
        logic [2:0] row;
        case (code)
            KEY_1, KEY_4, KEY_7, KEY_A: row = 3'b100;
            KEY_2, KEY_5, KEY_8, KEY_B: row = 3'b010;
            KEY_3, KEY_6, KEY_9, KEY_C: row = 3'b001;
            default:                    row = 3'b000;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/keypad_cmd_fifo.sv
// Small synchronous command FIFO. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module keypad_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge sys_clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; a reset flushes the queue.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Key-matrix side of a 4x3 scanned keypad. Queued key codes are pressed for
// HOLD_CYC cycles then released for GAP_CYC cycles; while pressed, the key's
// row follows its scan line combinationally.
//
// Command handshake: a code is taken on a rising sys_clk edge where
// key_valid && key_ready are both 1. key_ready depends only on queue fullness,
// never on key_valid. With key_valid=1 and key_ready=0 nothing is taken and
// the source keeps key_valid/key_code stable until a later accepting edge.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYC   = 8000,
    parameter int GAP_CYC    = 4000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] key_code,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       busy,
    output logic       err,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam logic [31:0] HOLD_LAST = HOLD_CYC - 1;
    localparam logic [31:0] GAP_LAST  = GAP_CYC - 1;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] cnt_inc;
    logic [3:0]  cur_key;

    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_rd_data;
    logic        pop;

    logic        scan_hit;
    logic [2:0]  row;

    assign pop       = (state == IDLE) && !fifo_empty;
    assign cnt_inc   = cnt + 32'd1;
    assign key_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign state_dbg = state;

    keypad_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (4)
    ) u_cmd_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (key_valid),
        .wr_data   (key_code),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Press/release sequencer with registered err and done pulses.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_key <= KEY_NONE;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (key_is_valid(fifo_rd_data)) begin
                            cur_key <= fifo_rd_data;
                            cnt     <= '0;
                            state   <= PRESS;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PRESS: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= GAP;
                        // A one-cycle gap makes its first cycle the last one.
                        done  <= (GAP_CYC == 1);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt  <= cnt_inc;
                        done <= (cnt_inc == GAP_LAST);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Row return: the held key's row mirrors its own scan line, zero-latency.
    always_comb begin
        row      = 3'b000;
        scan_hit = |(key_to_scan(cur_key) & {A, B, C, D});
        if ((state == PRESS) && scan_hit) begin
            row = key_to_row(cur_key);
        end
    end

    assign {E, F, G} = row;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: directed scenarios plus a randomized phase,
// every cycle compared against a timeline model of key presses.
module tb_keypad_emulator;

  localparam int HOLD  = 8;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic       key_ready, E, F, G, busy, err, done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  keypad_emulator #(
    .HOLD_CYC   (HOLD),
    .GAP_CYC    (GAP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .E         (E),
    .F         (F),
    .G         (G),
    .busy      (busy),
    .err       (err),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  // A key popped at cycle p is pressed during [p+1, p+HOLD], finishes its gap
  // at p+HOLD+GAP, and the engine is free again from cycle p+1+HOLD+GAP.
  logic [3:0] exp_q[$];
  longint     cyc = 0;
  bit         m_valid = 0;
  bit         m_active = 0;
  logic [3:0] m_key = 4'hf;
  longint     m_t0 = 0;
  longint     m_err_at = -1;
  bit         m_rdy;
  logic [3:0] m_code;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      exp_q.delete();
      m_active = 0;
      m_err_at = -1;
      m_valid  = 1;
    end else if (m_valid) begin
      m_rdy = (exp_q.size() < DEPTH);
      if (!(m_active && cyc < m_t0 + HOLD + GAP)) begin
        m_active = 0;
        if (exp_q.size() > 0) begin
          m_code = exp_q.pop_front();
          if (m_code >= 4'd1 && m_code <= 4'd12) begin
            m_active = 1;
            m_key    = m_code;
            m_t0     = cyc + 1;
          end else begin
            m_err_at = cyc + 1;
          end
        end
      end
      if (key_valid && m_rdy) exp_q.push_back(key_code);
    end
    cyc++;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  logic       e_press, e_hit;
  logic [2:0] e_row;
  int         col, rw;

  always @(negedge sys_clk) begin
    if (m_valid) begin
      e_press = m_active && (cyc >= m_t0) && (cyc < m_t0 + HOLD);
      col = (int'(m_key) - 1) / 3;
      rw  = (int'(m_key) - 1) % 3;
      case (col)
        0: e_hit = A;
        1: e_hit = B;
        2: e_hit = C;
        default: e_hit = D;
      endcase
      e_row = 3'b000;
      if (e_press && e_hit) e_row[2 - rw] = 1'b1;
      chk("rows", {29'd0, E, F, G}, {29'd0, e_row});
      chk("key_ready", {31'd0, key_ready}, {31'd0, exp_q.size() < DEPTH});
      chk("busy", {31'd0, busy}, {31'd0, (exp_q.size() > 0) || (m_active && cyc < m_t0 + HOLD + GAP)});
      chk("err", {31'd0, err}, {31'd0, cyc == m_err_at});
      chk("done", {31'd0, done}, {31'd0, m_active && cyc == m_t0 + HOLD + GAP - 1});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c);
    int n;
    n = 0;
    key_valid = 1'b1;
    key_code  = c;
    while (!key_ready && n < 300) begin
      step();
      n++;
    end
    if (!key_ready) chk("push_timeout", {31'd0, key_ready}, 32'd1);
    step();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    step();
  endtask

  task automatic set_scan(input logic [3:0] s);
    {A, B, C, D} = s;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst_n = 1'b0;
    step();
    step();
    // Reset values (cycle after the reset edge).
    chk("rst_ready", {31'd0, key_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rows", {29'd0, E, F, G}, 32'd0);
    chk("rst_pulses", {30'd0, err, done}, 32'd0);
    sys_rst_n = 1'b1;
    step();

    // Key 5 with B toggling: F follows B for exactly HOLD cycles.
    set_scan(4'b0100);
    push(4'h5);
    chk("t1_pre", {29'd0, E, F, G}, 32'd0);
    step();
    for (int i = 0; i < HOLD; i++) begin
      B = ~B;
      #1;
      chk("t1_f", {31'd0, F}, {31'd0, B});
      chk("t1_eg", {30'd0, E, G}, 32'd0);
      step();
    end
    B = 1'b1;
    #1;
    chk("t1_post", {29'd0, E, F, G}, 32'd0);
    step();
    step();
    step();
    chk("t1_done", {31'd0, done}, 32'd1);
    step();
    chk("t1_done_end", {31'd0, done}, 32'd0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    wait_idle();

    // Invalid code e, then a normal key 1.
    set_scan(4'b1000);
    push(4'he);
    step();
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_rows", {29'd0, E, F, G}, 32'd0);
    step();
    chk("t2_err_end", {31'd0, err}, 32'd0);
    push(4'h1);
    step();
    chk("t2_key1", {29'd0, E, F, G}, 32'd4);
    wait_idle();

    // Five consecutive pushes: the first pops at once, queue then fills.
    set_scan(4'b1000);
    for (int k = 1; k <= 5; k++) push(4'(k));
    chk("t3_full", {31'd0, key_ready}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset in the third PRESS cycle of key c.
    set_scan(4'b0001);
    push(4'hc);
    push(4'h1);
    push(4'h2);
    step();
    chk("t4_press", {31'd0, G}, 32'd1);
    sys_rst_n = 1'b0;
    step();
    chk("t4_g", {31'd0, G}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_ready", {31'd0, key_ready}, 32'd1);
    sys_rst_n = 1'b1;
    repeat (30) step();
    chk("t4_quiet", {31'd0, busy}, 32'd0);

    // Key 9 on the wrong scan line, then its own line.
    set_scan(4'b1000);
    push(4'h9);
    step();
    chk("t5_wrong", {29'd0, E, F, G}, 32'd0);
    C = 1'b1;
    #1;
    chk("t5_right", {29'd0, E, F, G}, 32'd1);
    wait_idle();

    // Randomized phase: random codes, random scan, occasional reset.
    for (int i = 0; i < 900; i++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom_range(0, 15));
      sys_rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 7) == 0) set_scan(4'($urandom_range(0, 15)));
      else set_scan(4'b0001 << $urandom_range(0, 3));
      step();
    end
    key_valid = 1'b0;
    sys_rst_n = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
